// File: rtl/dsp_coef_mem_server.sv
// Coefficient RAM serving 1-cycle-latency dsp reads, filled by a streaming
// valid/ready loader sequenced by a small IDLE/LOAD/DONE FSM.
module dsp_coef_mem_server #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] memaddr,
    output logic [DATA_W-1:0] memdout,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W:0]   FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0]   rem, rem_nxt, rem_init;
    logic              wr_en;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rem_init = (ld_count > FULL) ? FULL : ld_count;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rem_nxt    = rem;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    wr_ptr_nxt = ld_base;
                    rem_nxt    = rem_init;
                    state_nxt  = (rem_init == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // ld_ready is high exactly while in LOAD, so this is the handshake
                if (ld_valid && ld_ready) begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + PTR_ONE;
                    rem_nxt    = rem - REM_ONE;
                    if (rem == REM_ONE)
                        state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rem      <= '0;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            memdout  <= '0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rem      <= rem_nxt;
            ld_ready <= (state_nxt == LOAD);
            busy     <= (state_nxt == LOAD);
            done     <= (state_nxt == DONE);
            memdout  <= mem[memaddr];
        end
    end

    // RAM is not reset; reads above see the pre-write word on a collision
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= ld_data;
    end

endmodule

// File: tb/tb_dsp_coef_mem_server.sv
// Directed bench for dsp_coef_mem_server: a model RAM feeds a queue of
// expected memdout values that is drained one cycle after each read address.
module tb_dsp_coef_mem_server;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  memaddr;
    logic [13:0] memdout;
    logic        ld_start;
    logic [5:0]  ld_base;
    logic [6:0]  ld_count;
    logic        ld_valid;
    logic [13:0] ld_data;
    logic        ld_ready, busy, done;

    int          tests = 0;
    int          fails = 0;
    logic [13:0] model [64];
    logic [13:0] rd_q [$];
    logic [5:0]  m_ptr;
    int          m_rem;

    dsp_coef_mem_server #(.DATA_W(14), .ADDR_W(6), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .memaddr(memaddr), .memdout(memdout),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [13:0] e;
        @(negedge clk);
        if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            chk("memdout", 32'(memdout), 32'(e));
        end
    endtask

    task automatic drive_read(input logic [5:0] a);
        memaddr = a;
        rd_q.push_back(model[a]);
    endtask

    task automatic read_range(input logic [5:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            drive_read(a + 6'(i));
            tick();
        end
    endtask

    task automatic start_load(input logic [5:0] b, input logic [6:0] c);
        ld_start = 1'b1; ld_base = b; ld_count = c;
        m_ptr = b;
        m_rem = (c > 7'd64) ? 64 : int'(c);
        tick();
        ld_start = 1'b0;
        chk("ld_ready_after_start", 32'(ld_ready), 32'(m_rem != 0));
        chk("busy_after_start", 32'(busy), 32'(m_rem != 0));
        chk("done_after_start", 32'(done), 32'(m_rem == 0));
    endtask

    task automatic push_word(input logic [13:0] d);
        ld_valid = 1'b1; ld_data = d;
        model[m_ptr] = d;
        m_ptr = m_ptr + 6'd1;
        m_rem--;
        tick();
        ld_valid = 1'b0;
        chk("done_after_word", 32'(done), 32'(m_rem == 0));
        chk("ld_ready_after_word", 32'(ld_ready), 32'(m_rem != 0));
    endtask

    task automatic gap();
        ld_valid = 1'b0; ld_data = 14'h3FFF;
        tick();
        chk("gap_ld_ready", 32'(ld_ready), 32'd1);
        chk("gap_done", 32'(done), 32'd0);
    endtask

    task automatic finish_done();
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ld_ready", 32'(ld_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1; memaddr = '0; ld_start = 1'b0; ld_base = '0; ld_count = '0;
        ld_valid = 1'b0; ld_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_memdout", 32'(memdout), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // back-to-back load at base 0
        start_load(6'd0, 7'd4);
        for (int i = 1; i <= 4; i++) push_word(14'(i));
        finish_done();
        read_range(6'd0, 4);

        // wrap from 62 to 1; addr 2 must keep 0x0003
        start_load(6'd62, 7'd4);
        push_word(14'h1111); push_word(14'h2222);
        push_word(14'h3333); push_word(14'h0ABC);
        finish_done();
        read_range(6'd62, 5);

        // gapped stream 1,0,0,1,1
        start_load(6'd10, 7'd3);
        push_word(14'h0100); gap(); gap();
        push_word(14'h0200); push_word(14'h0300);
        finish_done();
        read_range(6'd10, 3);

        // read-before-write collision at addr 5
        start_load(6'd5, 7'd1);
        push_word(14'h0123);
        finish_done();
        start_load(6'd5, 7'd1);
        drive_read(6'd5);
        push_word(14'h2AAA);
        drive_read(6'd5);
        tick();
        finish_done();

        // zero-length load; ld_valid outside LOAD must not write
        ld_valid = 1'b1; ld_data = 14'h3FFF;
        start_load(6'd0, 7'd0);
        finish_done();
        ld_valid = 1'b0;
        read_range(6'd0, 6);

        // clamped load with a stray ld_start in the middle
        start_load(6'd0, 7'd100);
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                ld_start = 1'b1; ld_base = 6'd40; ld_count = 7'd3;
            end
            push_word(14'h1500 ^ 14'(i));
            ld_start = 1'b0;
        end
        ld_valid = 1'b1; ld_data = 14'h3FFF;
        finish_done();
        ld_valid = 1'b0;
        read_range(6'd0, 64);

        // reset after 2 of 5 words
        start_load(6'd30, 7'd5);
        push_word(14'h0AA1); push_word(14'h0AA2);
        #1 rst = 1'b1;
        #1;
        chk("midrst_memdout", 32'(memdout), 32'd0);
        chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        read_range(6'd30, 5);
        start_load(6'd30, 7'd1);
        push_word(14'h0777);
        finish_done();
        read_range(6'd30, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
